// File: rtl/spiking_network_pkg.sv
// -----------------------------------------------------------------------------
// spiking_network_pkg
// Shared constants for the spiking network block. It holds the SPI opcodes, the
// configuration memory map, the layer sizes, the synapse field widths and a
// helper that sign-extends a 2-bit weight.
// -----------------------------------------------------------------------------
package spiking_network_pkg;

    // Layer sizes
    localparam int N_INPUT  = 24;
    localparam int N_HIDDEN = 8;
    localparam int N_OUTPUT = 2;

    // Synapse fields and history depth
    localparam int WEIGHT_W     = 2;
    localparam int DELAY_W      = 4;
    localparam int HIST_DEPTH   = 16;
    localparam int N_SYNAPSE    = N_HIDDEN * N_INPUT + N_OUTPUT * N_HIDDEN;
    localparam int OUT_SYN_BASE = N_HIDDEN * N_INPUT;

    // Neuron datapath widths
    localparam int V_W     = 8;   // membrane potential, unsigned
    localparam int PARAM_W = 6;   // decay / refractory / threshold
    localparam int SUM_W   = 8;   // signed synaptic sum (hidden range -48..+24)

    // Memory map (byte addresses)
    localparam int MEM_BYTES       = 164;
    localparam int ADDR_INPUT0     = 0;
    localparam int ADDR_DECAY      = 3;
    localparam int ADDR_REFRACTORY = 4;
    localparam int ADDR_THRESHOLD  = 5;
    localparam int ADDR_DIV        = 6;
    localparam int ADDR_WEIGHT0    = 7;
    localparam int ADDR_DELAY0     = 59;
    localparam int ADDR_DEBUG_CFG  = 163;
    localparam int WEIGHT_BYTES    = N_SYNAPSE * WEIGHT_W / 8;   // 52
    localparam int DELAY_BYTES     = N_SYNAPSE * DELAY_W / 8;    // 104

    // Debug selector codes above the per-neuron potentials (0-7)
    localparam logic [3:0] DBG_HID_SPIKES = 4'd8;
    localparam logic [3:0] DBG_OUT_SPIKES = 4'd9;

    typedef enum logic [7:0] {
        OP_READ          = 8'h00,
        OP_WRITE         = 8'h01,
        OP_WRITE_CLR_DIV = 8'h05,
        OP_WRITE_B       = 8'h07,
        OP_WRITE_C       = 8'h09
    } opcode_e;

    function automatic logic is_write_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_WRITE_CLR_DIV) ||
               (op == OP_WRITE_B) || (op == OP_WRITE_C);
    endfunction

    function automatic logic signed [SUM_W-1:0] weight_value(input logic [WEIGHT_W-1:0] w);
        return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

endpackage

// File: rtl/spiking_network_lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
// One leaky integrate-and-fire neuron, updated only on the timestep tick.
// Ports:
//   system_clock, rst_n          clock, async active-low reset
//   tick                         timestep strobe
//   syn_sum                      signed sum of active synapse weights
//   decay, refractory, threshold shared neuron parameters
//   v                            membrane potential
//   spike                        spike from the most recent tick (held)
// -----------------------------------------------------------------------------
module lif_neuron
    import spiking_network_pkg::*;
(
    input  logic                    system_clock,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic signed [SUM_W-1:0] syn_sum,
    input  logic [PARAM_W-1:0]      decay,
    input  logic [PARAM_W-1:0]      refractory,
    input  logic [PARAM_W-1:0]      threshold,
    output logic [V_W-1:0]          v,
    output logic                    spike
);

    logic [PARAM_W-1:0]    r;
    logic [V_W-1:0]        leak;
    logic [V_W-1:0]        v_leaked;
    logic [V_W-1:0]        v_next;
    logic signed [V_W+2:0] acc;

    // NOTE: every always_comb output is assigned on every path (here by
    // straight-line code) so no latch is inferred.
    always_comb begin
        leak     = (v < V_W'(decay)) ? v : V_W'(decay);
        v_leaked = v - leak;
        acc      = $signed({3'b000, v_leaked}) + (V_W+3)'(syn_sum);
        if (acc < 0)
            v_next = '0;
        else if (acc > 11'sd255)
            v_next = '1;
        else
            v_next = acc[V_W-1:0];
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            r     <= '0;
            spike <= 1'b0;
        end else if (tick) begin
            if (r != '0) begin
                r     <= r - 1'b1;
                v     <= '0;
                spike <= 1'b0;
            end else if (v_next >= V_W'(threshold)) begin
                spike <= 1'b1;
                v     <= '0;
                r     <= refractory;
            end else begin
                v     <= v_next;
                spike <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spiking_network_top.sv
// -----------------------------------------------------------------------------
// spiking_network_top
// A 24-8-2 spiking network. Its 164-byte configuration memory is loaded over a
// 4-byte-instruction SPI slave (addr_msb, addr_lsb, opcode, data).
// Ports:
//   system_clock, rst_n  sole clock, async active-low reset
//   SCLK, MOSI, SS       SPI slave inputs, synchronised into system_clock
//   MISO                 read data, MSB first, during the data byte of a read
//   input_ready          enables timestep ticks
//   output_spikes        output-layer spikes of the last tick
//   data_valid_out       one-cycle pulse when output_spikes updates
//   spi_instruction_done one-cycle pulse per completed instruction
//   debug_output         debug view selected by byte 163
// Build option: define SPIKING_DEBUG_OUTPUT_EN to drive debug_output; without
// it, debug_output is constant 0x00.
// -----------------------------------------------------------------------------
module spiking_network_top
    import spiking_network_pkg::*;
(
    input  logic       system_clock,
    input  logic       rst_n,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS,
    input  logic       input_ready,
    output logic       MISO,
    output logic [7:0] debug_output,
    output logic [1:0] output_spikes,
    output logic       spi_instruction_done,
    output logic       data_valid_out
);

    // ---------------- SPI input synchronisers and edge detection -------------
    logic [2:0] sclk_sync;   // bit 2 is the previous synchronised value
    logic [1:0] mosi_sync;
    logic [2:0] ss_sync;

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;   // idle high, so reset release is not seen as a frame start
        end else begin
            sclk_sync <= {sclk_sync[1:0], SCLK};
            mosi_sync <= {mosi_sync[0], MOSI};
            ss_sync   <= {ss_sync[1:0], SS};
        end
    end

    logic sclk_rise, sclk_fall, ss_active, ss_fall, mosi_s;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_active = ~ss_sync[1];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign mosi_s    = mosi_sync[1];

    // ---------------- SPI byte engine and instruction decode ------------------
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [1:0] byte_cnt;
    logic [7:0] addr_q;
    logic [7:0] opcode_q;
    logic [7:0] tx_shift;
    logic [7:0] mem [MEM_BYTES];

    logic       byte_done, data_byte_done, addr_ok, mem_wr, div_clear;
    logic [7:0] rx_byte, rd_data;

    assign byte_done      = ss_active & sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte        = {rx_shift, mosi_s};
    assign data_byte_done = byte_done & (byte_cnt == 2'd3);
    assign addr_ok        = addr_q <= 8'(MEM_BYTES - 1);
    assign mem_wr         = data_byte_done & addr_ok & is_write_op(opcode_q);
    assign div_clear      = data_byte_done & (opcode_q == OP_WRITE_CLR_DIV);
    assign rd_data        = addr_ok ? mem[addr_q] : 8'h00;
    assign MISO           = tx_shift[7];

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt              <= '0;
            rx_shift             <= '0;
            byte_cnt             <= '0;
            addr_q               <= '0;
            opcode_q             <= '0;
            tx_shift             <= '0;
            spi_instruction_done <= 1'b0;
        end else begin
            spi_instruction_done <= data_byte_done;
            if (!ss_active) begin
                // Frame closed: a partial byte is dropped, MISO returns low.
                bit_cnt  <= '0;
                tx_shift <= '0;
            end else begin
                if (sclk_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    rx_shift <= rx_byte[6:0];
                end
                // The read byte is loaded at frame start so its MSB is ready
                // before the master's first sampling edge.
                if (ss_fall)
                    tx_shift <= (byte_cnt == 2'd3 && opcode_q == OP_READ) ? rd_data : 8'h00;
                else if (sclk_fall)
                    tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (byte_done) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd1) addr_q   <= rx_byte;
                if (byte_cnt == 2'd2) opcode_q <= rx_byte;
            end
        end
    end

    // NOTE: the configuration memory is reset explicitly because the network
    // must start from all-zero parameters; this keeps it in flops, not RAM.
    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < MEM_BYTES; j++) mem[j] <= '0;
        end else if (mem_wr) begin
            mem[addr_q] <= rx_byte;
        end
    end

    // ---------------- Configuration fields ------------------------------------
    logic [N_INPUT-1:0]            in_vec;
    logic [PARAM_W-1:0]            decay, refractory, threshold;
    logic [7:0]                    div_value, debug_config;
    logic [N_SYNAPSE*WEIGHT_W-1:0] weight_bits;
    logic [N_SYNAPSE*DELAY_W-1:0]  delay_bits;

    assign in_vec       = {mem[ADDR_INPUT0+2], mem[ADDR_INPUT0+1], mem[ADDR_INPUT0]};
    assign decay        = mem[ADDR_DECAY][PARAM_W-1:0];
    assign refractory   = mem[ADDR_REFRACTORY][PARAM_W-1:0];
    assign threshold    = mem[ADDR_THRESHOLD][PARAM_W-1:0];
    assign div_value    = mem[ADDR_DIV];
    assign debug_config = mem[ADDR_DEBUG_CFG];

    for (genvar j = 0; j < WEIGHT_BYTES; j++) begin : g_weight_bytes
        assign weight_bits[8*j +: 8] = mem[ADDR_WEIGHT0 + j];
    end
    for (genvar j = 0; j < DELAY_BYTES; j++) begin : g_delay_bytes
        assign delay_bits[8*j +: 8] = mem[ADDR_DELAY0 + j];
    end

    // ---------------- Timestep divider ----------------------------------------
    logic [7:0] div_cnt;
    logic       tick;
    assign tick = input_ready & (div_cnt == div_value);

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (div_clear || !input_ready || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 8'd1;
    end

    // ---------------- Spike histories -----------------------------------------
    // Entry 0 of the effective history is the live value (current input bytes,
    // hidden spikes of the previous tick); the stored registers hold entries 1-15.
    logic [N_INPUT-1:0]  in_hist  [HIST_DEPTH-1];
    logic [N_HIDDEN-1:0] hid_hist [HIST_DEPTH-1];
    logic [N_INPUT-1:0]  in_eff   [HIST_DEPTH];
    logic [N_HIDDEN-1:0] hid_eff  [HIST_DEPTH];
    logic [N_HIDDEN-1:0] hid_spikes;

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < HIST_DEPTH - 1; d++) begin
                in_hist[d]  <= '0;
                hid_hist[d] <= '0;
            end
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= tick;
            if (tick) begin
                in_hist[0]  <= in_vec;
                hid_hist[0] <= hid_spikes;
                for (int d = 1; d < HIST_DEPTH - 1; d++) begin
                    in_hist[d]  <= in_hist[d-1];
                    hid_hist[d] <= hid_hist[d-1];
                end
            end
        end
    end

    always_comb begin
        in_eff[0]  = in_vec;
        hid_eff[0] = hid_spikes;
        for (int d = 1; d < HIST_DEPTH; d++) begin
            in_eff[d]  = in_hist[d-1];
            hid_eff[d] = hid_hist[d-1];
        end
    end

    // ---------------- Synaptic sums -------------------------------------------
    logic signed [SUM_W-1:0] hid_sum [N_HIDDEN];
    logic signed [SUM_W-1:0] out_sum [N_OUTPUT];

    always_comb begin
        for (int h = 0; h < N_HIDDEN; h++) begin
            hid_sum[h] = '0;
            for (int i = 0; i < N_INPUT; i++) begin
                if (in_eff[delay_bits[DELAY_W*(h*N_INPUT+i) +: DELAY_W]][i])
                    hid_sum[h] = hid_sum[h] +
                                 weight_value(weight_bits[WEIGHT_W*(h*N_INPUT+i) +: WEIGHT_W]);
            end
        end
        for (int o = 0; o < N_OUTPUT; o++) begin
            out_sum[o] = '0;
            for (int h = 0; h < N_HIDDEN; h++) begin
                if (hid_eff[delay_bits[DELAY_W*(OUT_SYN_BASE+o*N_HIDDEN+h) +: DELAY_W]][h])
                    out_sum[o] = out_sum[o] +
                                 weight_value(weight_bits[WEIGHT_W*(OUT_SYN_BASE+o*N_HIDDEN+h) +: WEIGHT_W]);
            end
        end
    end

    // ---------------- Neurons --------------------------------------------------
    logic [V_W-1:0] hid_v [N_HIDDEN];
    logic [V_W-1:0] out_v [N_OUTPUT];

    for (genvar h = 0; h < N_HIDDEN; h++) begin : g_hidden
        lif_neuron u_neuron (
            .system_clock (system_clock),
            .rst_n        (rst_n),
            .tick         (tick),
            .syn_sum      (hid_sum[h]),
            .decay        (decay),
            .refractory   (refractory),
            .threshold    (threshold),
            .v            (hid_v[h]),
            .spike        (hid_spikes[h])
        );
    end

    for (genvar o = 0; o < N_OUTPUT; o++) begin : g_output
        lif_neuron u_neuron (
            .system_clock (system_clock),
            .rst_n        (rst_n),
            .tick         (tick),
            .syn_sum      (out_sum[o]),
            .decay        (decay),
            .refractory   (refractory),
            .threshold    (threshold),
            .v            (out_v[o]),
            .spike        (output_spikes[o])
        );
    end

    // ---------------- Debug view ----------------------------------------------
`ifdef SPIKING_DEBUG_OUTPUT_EN
    logic [7:0] debug_next;

    always_comb begin
        debug_next = 8'h00;
        if (!debug_config[3])
            debug_next = hid_v[debug_config[2:0]];
        else if (debug_config[3:0] == DBG_HID_SPIKES)
            debug_next = hid_spikes;
        else if (debug_config[3:0] == DBG_OUT_SPIKES)
            debug_next = {6'b0, output_spikes};
    end

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n)
            debug_output <= '0;
        else
            debug_output <= debug_next;
    end

    logic unused_bits;
    assign unused_bits = ^{debug_config[7:4], out_v[0], out_v[1],
                           mem[ADDR_DECAY][7:6], mem[ADDR_REFRACTORY][7:6],
                           mem[ADDR_THRESHOLD][7:6]};
`else
    assign debug_output = 8'h00;

    logic unused_bits;
    assign unused_bits = ^{debug_config, out_v[0], out_v[1],
                           hid_v[0], hid_v[1], hid_v[2], hid_v[3],
                           hid_v[4], hid_v[5], hid_v[6], hid_v[7],
                           mem[ADDR_DECAY][7:6], mem[ADDR_REFRACTORY][7:6],
                           mem[ADDR_THRESHOLD][7:6]};
`endif

endmodule

// File: tb/tb_spiking_network_top.sv
// -----------------------------------------------------------------------------
// tb_spiking_network_top
// Directed bench for spiking_network_top. Drives SPI instructions, checks
// read-back, the timestep period and the network's spike behaviour against
// hand-computed values. Expected debug values follow SPIKING_DEBUG_OUTPUT_EN.
// -----------------------------------------------------------------------------
module tb_spiking_network_top;

    logic       system_clock = 1'b0;
    logic       rst_n        = 1'b0;
    logic       SCLK         = 1'b0;
    logic       MOSI         = 1'b0;
    logic       SS           = 1'b1;
    logic       input_ready  = 1'b0;
    logic       MISO;
    logic [7:0] debug_output;
    logic [1:0] output_spikes;
    logic       spi_instruction_done;
    logic       data_valid_out;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int done_cnt  = 0;

    always #5 system_clock = ~system_clock;

    spiking_network_top dut (
        .system_clock         (system_clock),
        .rst_n                (rst_n),
        .SCLK                 (SCLK),
        .MOSI                 (MOSI),
        .SS                   (SS),
        .input_ready          (input_ready),
        .MISO                 (MISO),
        .debug_output         (debug_output),
        .output_spikes        (output_spikes),
        .spi_instruction_done (spi_instruction_done),
        .data_valid_out       (data_valid_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance n falling edges, counting instruction-done pulses on the way.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge system_clock);
            if (spi_instruction_done) done_cnt++;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        SS = 1'b0;
        step(6);
        for (int b = 7; b >= 0; b--) begin
            MOSI = tx[b];
            step(4);
            rx[b] = MISO;
            SCLK = 1'b1;
            step(4);
            SCLK = 1'b0;
        end
        step(4);
        SS   = 1'b1;
        MOSI = 1'b0;
        step(4);
    endtask

    task automatic spi_partial(input int nbits);
        SS = 1'b0;
        step(6);
        for (int b = 0; b < nbits; b++) begin
            MOSI = 1'b1;
            step(4);
            SCLK = 1'b1;
            step(4);
            SCLK = 1'b0;
        end
        step(4);
        SS   = 1'b1;
        MOSI = 1'b0;
        step(4);
    endtask

    task automatic spi_instr(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             output logic [7:0] rd);
        logic [7:0] unused;
        spi_byte(b0, unused);
        spi_byte(b1, unused);
        spi_byte(b2, unused);
        spi_byte(b3, rd);
    endtask

    task automatic write_mem(input logic [7:0] addr, input logic [7:0] data, input logic [7:0] op);
        logic [7:0] rd;
        spi_instr(8'h00, addr, op, data, rd);
    endtask

    task automatic read_mem(input logic [7:0] addr, output logic [7:0] data);
        spi_instr(8'h00, addr, 8'h00, 8'h00, data);
    endtask

    // Returns on the falling edge where data_valid_out is high.
    task automatic wait_tick();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!data_valid_out && n < 40);
        check("tick_seen", data_valid_out, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd, r0, r1, r2, exp_dbg;
        int         n, pulses;

        // Reset state
        step(4);
        check("rst_miso", MISO, 0);
        check("rst_debug", debug_output, 8'h00);
        check("rst_spikes", output_spikes, 2'b00);
        check("rst_done", spi_instruction_done, 0);
        check("rst_valid", data_valid_out, 0);
        rst_n = 1'b1;
        step(4);

        // Write 0xA5 to 0x34, then read it back
        done_cnt = 0;
        spi_instr(8'h12, 8'h34, 8'h01, 8'hA5, rd);
        spi_instr(8'h45, 8'h34, 8'h00, 8'h00, rd);
        check("read_0x34", rd, 8'hA5);
        check("done_pulses", done_cnt, 2);

        // Unknown opcode leaves MISO low and does not write
        spi_instr(8'h00, 8'h34, 8'h02, 8'h11, rd);
        check("nop_miso", rd, 8'h00);
        read_mem(8'h34, rd);
        check("nop_no_write", rd, 8'hA5);

        // Address boundary: 163 is the last byte, 164 is out of range
        write_mem(8'hA4, 8'h77, 8'h01);
        read_mem(8'hA4, rd);
        check("addr164_read", rd, 8'h00);
        write_mem(8'hA3, 8'h3C, 8'h09);
        read_mem(8'hA3, rd);
        check("addr163_read", rd, 8'h3C);

        // A partial byte is discarded without shifting the byte count
        spi_partial(5);
        read_mem(8'h34, rd);
        check("partial_byte", rd, 8'hA5);

        // Input vector via opcode 0x07
        write_mem(8'h00, 8'hBA, 8'h07);
        write_mem(8'h01, 8'hDC, 8'h07);
        write_mem(8'h02, 8'hFE, 8'h07);
        read_mem(8'h00, r0);
        read_mem(8'h01, r1);
        read_mem(8'h02, r2);
        check("input_vector", {8'h00, r2, r1, r0}, 32'h00FE_DCBA);

        // Divider: period div_value+1, silent when input_ready is low
        write_mem(8'h06, 8'h03, 8'h05);
        input_ready = 1'b1;
        wait_tick();
        n = 0;
        do begin
            step(1);
            n++;
        end while (!data_valid_out && n < 20);
        check("tick_period", n, 4);
        pulses = 0;
        repeat (40) begin
            step(1);
            pulses += int'(data_valid_out);
        end
        check("ticks_in_40", pulses, 10);
        input_ready = 1'b0;
        pulses = 0;
        repeat (40) begin
            step(1);
            pulses += int'(data_valid_out);
        end
        check("ticks_disabled", pulses, 0);

        // Threshold 5, zero weights, all inputs active: no output spikes
        write_mem(8'h05, 8'h05, 8'h01);
        write_mem(8'h03, 8'h00, 8'h01);
        write_mem(8'h04, 8'h00, 8'h01);
        write_mem(8'h00, 8'hFF, 8'h01);
        write_mem(8'h01, 8'hFF, 8'h01);
        write_mem(8'h02, 8'hFF, 8'h01);
        input_ready = 1'b1;
        wait_tick();
        check("zero_w_tick1", output_spikes, 2'b00);
        wait_tick();
        check("zero_w_tick2", output_spikes, 2'b00);
        input_ready = 1'b0;

        // All weights +1: hidden fire every tick, outputs from the second tick
        for (int j = 7; j <= 58; j++) write_mem(8'(j), 8'h55, 8'h01);
        write_mem(8'hA3, 8'h08, 8'h01);
        input_ready = 1'b1;
        wait_tick();
        check("pos_w_tick1", output_spikes, 2'b00);
        wait_tick();
        check("pos_w_tick2", output_spikes, 2'b11);
        wait_tick();
        check("pos_w_tick3", output_spikes, 2'b11);
        step(1);
`ifdef SPIKING_DEBUG_OUTPUT_EN
        exp_dbg = 8'hFF;
`else
        exp_dbg = 8'h00;
`endif
        check("debug_hid_spikes", debug_output, exp_dbg);
        input_ready = 1'b0;
        write_mem(8'hA3, 8'h09, 8'h01);
        step(2);
`ifdef SPIKING_DEBUG_OUTPUT_EN
        exp_dbg = 8'h03;
`else
        exp_dbg = 8'h00;
`endif
        check("debug_out_spikes", debug_output, exp_dbg);

        // Refractory 1: outputs follow 11, 00, 00, 11
        write_mem(8'h04, 8'h01, 8'h01);
        input_ready = 1'b1;
        wait_tick();
        check("refr_tick1", output_spikes, 2'b11);
        wait_tick();
        check("refr_tick2", output_spikes, 2'b00);
        wait_tick();
        check("refr_tick3", output_spikes, 2'b00);
        wait_tick();
        check("refr_tick4", output_spikes, 2'b11);
        input_ready = 1'b0;

        // Reset in the middle of an instruction
        spi_byte(8'h12, rd);
        spi_byte(8'h34, rd);
        rst_n = 1'b0;
        step(3);
        check("midrst_spikes", output_spikes, 2'b00);
        rst_n = 1'b1;
        step(3);
        read_mem(8'h34, rd);
        check("midrst_mem_cleared", rd, 8'h00);
        write_mem(8'h20, 8'h5A, 8'h01);
        read_mem(8'h20, rd);
        check("midrst_write_read", rd, 8'h5A);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
